fpadd_phase1_seq: RTL and testbench

FPADD_PHASE1_SEQ -- requirements
Module: fpadd_phase1_seq

---
 rtl/fpadd_ctrl_pkg.sv | 15 +
 rtl/phase1_op_counter.sv | 26 ++
 rtl/fpadd_phase1_seq.sv | 100 ++++++++++
 tb/tb_fpadd_phase1_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_ctrl_pkg.sv
// Shared types and defaults for the FP adder first-phase sequencer.
// The state encoding is fixed so external debug probes can decode it.
package fpadd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CMP  = 3'd2,
    ST_SEL  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/phase1_op_counter.sv
// Wrapping counter of completed first-phase operations.
// The counter is cleared only by the asynchronous reset.
module phase1_op_counter
  import fpadd_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/fpadd_phase1_seq.sv
// First-phase control FSM of the FP adder: load, compare, select, then hold the result.
// Define PHASE1_OP_COUNT_EN to add the op_cnt completed-operation counter.
module fpadd_phase1_seq
  import fpadd_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_fsm,
  input  logic             ack_fsm,
  input  logic             clr,
  output logic             ctrl_a,
  output logic             ctrl_b,
  output logic             ctrl_c,
  output logic             busy,
  output logic             ready
`ifdef PHASE1_OP_COUNT_EN
  ,
  output logic [CNT_W-1:0] op_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // clr wins over everything; unknown encodings fall back to IDLE.
  always_comb begin
    state_next = ST_IDLE;
    if (!clr) begin
      case (state_reg)
        ST_IDLE: state_next = beg_fsm ? ST_LOAD : ST_IDLE;
        ST_LOAD: state_next = ST_CMP;
        ST_CMP:  state_next = ST_SEL;
        ST_SEL:  state_next = ST_DONE;
        ST_DONE: begin
          if (ack_fsm) begin
            state_next = beg_fsm ? ST_LOAD : ST_IDLE;
          end else begin
            state_next = ST_DONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_a = 1'b0;
    ctrl_b = 1'b0;
    ctrl_c = 1'b0;
    busy   = 1'b0;
    ready  = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        ctrl_a = 1'b1;
        busy   = 1'b1;
      end
      ST_CMP: begin
        ctrl_b = 1'b1;
        busy   = 1'b1;
      end
      ST_SEL: begin
        ctrl_c = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: ready = 1'b1;
      default: ;
    endcase
  end

`ifdef PHASE1_OP_COUNT_EN
  logic done_exit;

  // An abort in DONE leaves without completing, so it is not counted.
  assign done_exit = (state_reg == ST_DONE) && ack_fsm && !clr;

  phase1_op_counter #(
    .CNT_W(CNT_W)
  ) u_op_counter (
    .clk(clk),
    .rst(rst),
    .inc(done_exit),
    .cnt(op_cnt)
  );
`endif

endmodule

// File: tb/tb_fpadd_phase1_seq.sv
// Directed bench for fpadd_phase1_seq with hand-computed strobe/state expectations.
// Output vector order is {ctrl_a, ctrl_b, ctrl_c, busy, ready}.
module tb_fpadd_phase1_seq;

  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_LOAD = 5'b10010;
  localparam logic [4:0] O_CMP  = 5'b01010;
  localparam logic [4:0] O_SEL  = 5'b00110;
  localparam logic [4:0] O_DONE = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beg_fsm = 1'b0;
  logic ack_fsm = 1'b0;
  logic clr = 1'b0;
  logic ctrl_a, ctrl_b, ctrl_c, busy, ready;
`ifdef PHASE1_OP_COUNT_EN
  logic [1:0] op_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_cnt = 2'd0;

  always #5 clk = ~clk;

  fpadd_phase1_seq #(
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .beg_fsm(beg_fsm),
    .ack_fsm(ack_fsm),
    .clr(clr),
    .ctrl_a(ctrl_a),
    .ctrl_b(ctrl_b),
    .ctrl_c(ctrl_c),
    .busy(busy),
    .ready(ready)
`ifdef PHASE1_OP_COUNT_EN
    ,
    .op_cnt(op_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, ctrl_a, ctrl_b, ctrl_c, busy, ready}, {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PHASE1_OP_COUNT_EN
    chk(tag, {30'd0, op_cnt}, {30'd0, exp_cnt});
`else
    $display("  %s: op_cnt not built", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From LOAD (already checked) through CMP and SEL into DONE.
  task automatic rest_to_done(input string tag);
    tick(); chk_outs({tag, "_cmp"}, O_CMP);
    tick(); chk_outs({tag, "_sel"}, O_SEL);
    tick(); chk_outs({tag, "_done"}, O_DONE);
  endtask

  task automatic go_done(input string tag);
    beg_fsm = 1'b1;
    tick();
    beg_fsm = 1'b0;
    chk_outs({tag, "_load"}, O_LOAD);
    rest_to_done(tag);
  endtask

  task automatic ack_idle(input string tag);
    ack_fsm = 1'b1;
    tick();
    ack_fsm = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    chk_outs({tag, "_idle"}, O_IDLE);
    chk_cnt({tag, "_cnt"});
    $display("op %s complete, expected count %0d", tag, exp_cnt);
  endtask

  initial begin
    // Reset: force a real negedge on rst.
    #1 rst = 1'b0;
    #1;
    chk_outs("rst_async", O_IDLE);
    chk_cnt("rst_cnt");
    beg_fsm = 1'b1;
    tick();
    chk_outs("rst_hold_beg", O_IDLE);
    beg_fsm = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    chk_outs("post_rst_idle", O_IDLE);

    // Single operation, DONE holds until ack.
    go_done("single");
    tick(); chk_outs("single_hold1", O_DONE);
    tick(); chk_outs("single_hold2", O_DONE);
    ack_idle("single");

    // ack in IDLE is ignored.
    ack_fsm = 1'b1;
    tick();
    ack_fsm = 1'b0;
    chk_outs("idle_ack_ign", O_IDLE);
    chk_cnt("idle_ack_cnt");

    // Back-to-back: ack with beg goes straight to LOAD.
    go_done("b2b1");
    ack_fsm = 1'b1;
    beg_fsm = 1'b1;
    tick();
    ack_fsm = 1'b0;
    beg_fsm = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    chk_outs("b2b_load", O_LOAD);
    chk_cnt("b2b_cnt1");
    rest_to_done("b2b2");
    ack_idle("b2b2");

    // Ignored inputs: beg in CMP, ack in SEL.
    beg_fsm = 1'b1;
    tick();
    beg_fsm = 1'b0;
    chk_outs("ign_load", O_LOAD);
    tick(); chk_outs("ign_cmp", O_CMP);
    beg_fsm = 1'b1;
    tick();
    beg_fsm = 1'b0;
    chk_outs("ign_sel", O_SEL);
    ack_fsm = 1'b1;
    tick();
    ack_fsm = 1'b0;
    chk_outs("ign_done", O_DONE);
    tick(); chk_outs("ign_wait", O_DONE);
    chk_cnt("ign_cnt_wait");
    ack_idle("ign");
    tick(); chk_outs("ign_no_queue", O_IDLE);

    // Abort in CMP, clr beats beg.
    beg_fsm = 1'b1;
    tick();
    beg_fsm = 1'b0;
    chk_outs("abort_load", O_LOAD);
    tick(); chk_outs("abort_cmp", O_CMP);
    clr = 1'b1;
    beg_fsm = 1'b1;
    tick();
    clr = 1'b0;
    beg_fsm = 1'b0;
    chk_outs("abort_idle", O_IDLE);
    tick(); chk_outs("abort_no_sel", O_IDLE);
    chk_cnt("abort_cnt");

    // Abort in DONE with ack and beg: no increment, no restart.
    go_done("abort2");
    clr = 1'b1;
    ack_fsm = 1'b1;
    beg_fsm = 1'b1;
    tick();
    clr = 1'b0;
    ack_fsm = 1'b0;
    beg_fsm = 1'b0;
    chk_outs("abort_done_idle", O_IDLE);
    chk_cnt("abort_done_cnt");

    // Asynchronous reset between edges while in SEL.
    beg_fsm = 1'b1;
    tick();
    beg_fsm = 1'b0;
    tick();
    tick();
    chk_outs("arst_pre_sel", O_SEL);
    #2 rst = 1'b0;
    #1;
    exp_cnt = 2'd0;
    chk_outs("arst_immediate", O_IDLE);
    chk_cnt("arst_cnt");
    tick(); chk_outs("arst_no_strobe", O_IDLE);
    @(negedge clk) rst = 1'b1;
    tick();
    chk_outs("arst_release", O_IDLE);
    go_done("arst_after");
    ack_idle("arst_after");

    // Wrap with CNT_W=2: count continues 2,3,0,1.
    for (int i = 0; i < 4; i++) begin
      go_done($sformatf("wrap%0d", i));
      ack_idle($sformatf("wrap%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
